// File: rtl/eq_ram_pkg.sv
// eq_ram_pkg: shared definitions for the equaliser tap ring buffer.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default tap count and sample width
//   state_e                       : controller states
//   wrap_sub                      : (base - off) mod depth without underflow
package eq_ram_pkg;

  localparam int DEFAULT_DEPTH = 279;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Both operands must already be below depth, so the result stays in 0..depth-1.
  function automatic int unsigned wrap_sub(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned depth);
    if (base >= off) return base - off;
    else             return base + depth - off;
  endfunction

endpackage

// File: rtl/eq_sdp_ram.sv
// eq_sdp_ram: simple dual-port RAM, one write port and one read port with a
// registered output. The output register only loads when re is high, so the
// read data holds while the consumer stalls.
//   clk, rst_n          : clock, async active-low reset (output register only)
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port, rdata valid one edge after re
module eq_sdp_ram
  import eq_ram_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

  a_raddr_range: assert property (@(posedge clk) disable iff (!rst_n)
                                  re |-> (int'(raddr) < DEPTH));
  a_waddr_range: assert property (@(posedge clk) disable iff (!rst_n)
                                  we |-> (int'(waddr) < DEPTH));

endmodule

// File: rtl/eq_tap_ring_buffer.sv
// eq_tap_ring_buffer: circular history of the last DEPTH samples for the FIR
// equaliser. Each accepted sample triggers a burst of the whole history,
// newest (tap 0) to oldest (tap DEPTH-1).
//   clk, rst_n                   : clock, async active-low reset
//   in_valid, in_ready, in_data  : sample input handshake
//   out_valid, out_ready         : tap output handshake
//   out_data, out_tap, out_last  : stored sample, tap index, last-tap flag
//   busy                         : high whenever the controller is not IDLE
// Build option: define EQ_TAP_RING_CLEAR_EN to zero the history after reset.
//
// state | meaning
// IDLE  | waiting for a sample (in_ready low only in the cycle after reset)
// BURST | streaming taps 0..DEPTH-1 to the MAC
// CLEAR | writing zeros to every address after reset (EQ_TAP_RING_CLEAR_EN)
module eq_tap_ring_buffer
  import eq_ram_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_tap,
  output logic             out_last,
  output logic             busy
);

  // rd_cnt must reach DEPTH to mark "all reads issued".
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  state_e          state_d, state_q;
  logic [AW-1:0]   wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]   base_d, base_q;
  logic [CW-1:0]   rd_cnt_d, rd_cnt_q;
  logic            in_ready_d, in_ready_q;
  logic            out_valid_d, out_valid_q;
  logic [AW-1:0]   out_tap_d, out_tap_q;
  logic            out_last_d, out_last_q;

  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [WIDTH-1:0] ram_wdata;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    rd_cnt_d    = rd_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_tap_d   = out_tap_q;
    out_last_d  = out_last_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q;
    ram_wdata   = in_data;
    ram_re      = 1'b0;
    ram_raddr   = AW'(wrap_sub(32'(base_q), 32'(rd_cnt_q), 32'(DEPTH)));

    case (state_q)
      IDLE: begin
        if (!in_ready_q) begin
          // Only reachable straight out of reset.
`ifdef EQ_TAP_RING_CLEAR_EN
          state_d    = CLEAR;
`else
          in_ready_d = 1'b1;
`endif
        end else if (in_valid) begin
          ram_we     = 1'b1;
          base_d     = wr_ptr_q;
          wr_ptr_d   = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
          rd_cnt_d   = '0;
          in_ready_d = 1'b0;
          state_d    = BURST;
        end
      end

      BURST: begin
        if ((rd_cnt_q < DEPTH_CNT) && (!out_valid_q || out_ready)) begin
          ram_re      = 1'b1;
          out_valid_d = 1'b1;
          out_tap_d   = rd_cnt_q[AW-1:0];
          out_last_d  = (rd_cnt_q == LAST_CNT);
          rd_cnt_d    = rd_cnt_q + CW'(1);
        end else if (out_valid_q && out_ready) begin
          // All reads issued; this is the last beat leaving.
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
          end
        end
      end

`ifdef EQ_TAP_RING_CLEAR_EN
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = '0;
        if (wr_ptr_q == LAST_ADDR) begin
          wr_ptr_d   = '0;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_tap_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_tap_q   <= out_tap_d;
      out_last_q  <= out_last_d;
    end
  end

  eq_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (out_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_tap   = out_tap_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_eq_tap_ring_buffer.sv
// Bench for eq_tap_ring_buffer at DEPTH=5 (non-power-of-2). The reference is a
// queue of the accepted samples, newest first; tap k of a burst must equal
// entry k. Entries never written since reset are zero when the design is built
// with EQ_TAP_RING_CLEAR_EN and are not compared otherwise.
module tb_eq_tap_ring_buffer;

  localparam int DEPTH = 5;
  localparam int WIDTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_tap;
  logic             out_last;
  logic             busy;

  int n_cmp;
  int n_err;
  logic [WIDTH-1:0] hist [$];

  eq_tap_ring_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tap   (out_tap),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Asserts reset (outputs must clear immediately), releases it, then checks
  // the CLEAR window or the immediate IDLE entry.
  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd0);
    check_eq("rst_out_last",  32'(out_last),  32'd0);
    check_eq("rst_out_tap",   32'(out_tap),   32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    hist.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef EQ_TAP_RING_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("clr_busy",     32'(busy),     32'd1);
      check_eq("clr_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
`endif
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("idle_busy",     32'(busy),     32'd0);
  endtask

  // Sends one sample and follows its burst to the end.
  //   stall_pct : chance (percent) of out_ready low on any beat
  //   hold      : keep in_valid high with hold_data during the burst
  //   stall_at  : tap that gets a forced 3-cycle out_ready stall (-1 none)
  //   abort_at  : tap at which reset is asserted mid-burst (-1 none)
  task automatic do_burst(input logic [WIDTH-1:0] s, input int stall_pct,
                          input bit hold, input logic [WIDTH-1:0] hold_data,
                          input int stall_at, input int abort_at);
    int k;
    int guard;
    int stall_left;
    guard = 0;
    while (!in_ready && guard < 4 * DEPTH) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("in_ready_wait", 32'(in_ready), 32'd1);
    if (!in_ready) return;

    in_valid = 1'b1;
    in_data  = s;
    @(posedge clk); #1;
    hist.push_front(s);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    check_eq("acc_out_valid", 32'(out_valid), 32'd0);
    check_eq("acc_in_ready",  32'(in_ready),  32'd0);
    check_eq("acc_busy",      32'(busy),      32'd1);

    k = 0;
    guard = 0;
    stall_left = -1;
    out_ready = 1'b0;
    while (k < DEPTH && guard < 40 * DEPTH) begin
      in_valid = hold ? 1'b1 : 1'($urandom_range(1));
      in_data  = hold ? hold_data : WIDTH'($urandom);
      @(posedge clk); #1;
      guard++;
      check_eq("beat_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        check_eq("beat_tap",      32'(out_tap),  32'(k));
        check_eq("beat_last",     32'(out_last), 32'(k == DEPTH - 1));
        check_eq("beat_in_ready", 32'(in_ready), 32'd0);
        check_eq("beat_busy",     32'(busy),     32'd1);
        if (k < hist.size()) check_eq("beat_data", 32'(out_data), 32'(hist[k]));
`ifdef EQ_TAP_RING_CLEAR_EN
        else check_eq("beat_prefill", 32'(out_data), 32'd0);
`endif
        if (k == abort_at) begin
          apply_reset();
          return;
        end
        if (k == stall_at && stall_left < 0) stall_left = 3;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(99) >= 32'(stall_pct));
        end
        if (out_ready) k++;
      end
    end
    check_eq("burst_done", 32'(k), 32'(DEPTH));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("end_out_valid", 32'(out_valid), 32'd0);
    check_eq("end_in_ready",  32'(in_ready),  32'd1);
    check_eq("end_busy",      32'(busy),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    apply_reset();

    // Ordering from a fresh history.
    for (int v = 1; v <= 3; v++) do_burst(WIDTH'(v), 0, 1'b0, '0, -1, -1);

    // Wrap-around of the write pointer at DEPTH=5.
    for (int v = 10; v <= 17; v++) do_burst(WIDTH'(v), 0, 1'b0, '0, -1, -1);

    // Forced stall on tap 1.
    do_burst(16'h0055, 0, 1'b0, '0, 1, -1);

    // Held in_valid during a burst: only the next burst takes 0x8000.
    do_burst(16'h7FFF, 0, 1'b1, 16'h8000, -1, -1);
    do_burst(16'h8000, 0, 1'b0, '0, -1, -1);

    // Random data and random backpressure.
    for (int i = 0; i < 20; i++)
      do_burst(WIDTH'($urandom), int'($urandom_range(60)), 1'b0, '0, -1, -1);

    // Reset at tap 2, then a fresh burst after recovery.
    do_burst(16'h1234, 0, 1'b0, '0, -1, 2);
    do_burst(16'h4321, 0, 1'b0, '0, -1, -1);
    do_burst(16'hBEEF, 30, 1'b0, '0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eq_tap_ring_buffer.md
Name: eq_tap_ring_buffer

Overview:
- Circular sample history for the FIR equaliser. Stores the last DEPTH input samples.
- On each accepted sample it streams the full history, newest to oldest, with a tap index so the downstream MAC can pair each sample with its coefficient.
- Generalises the single-port coefficient RAM: synchronous registered read, wrap-around addressing for non-power-of-2 depth, valid/ready handshakes on both sides, and optional post-reset clear.

Parameters:
- DEPTH, 279, number of taps and stored samples; any value >= 2, need not be a power of 2.
- WIDTH, 16, sample width in bits, signed two's complement.
- AW, $clog2(DEPTH), address and tap-index width; localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  new sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  signed sample.
- out_valid  out  1  out_data/out_tap/out_last valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  stored sample.
- out_tap  out  AW  tap index: 0 = newest, DEPTH-1 = oldest.
- out_last  out  1  high on the tap DEPTH-1 beat.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state, wr_ptr = 0, rd_cnt = 0, in_ready = 0, out_valid = 0, out_last = 0, out_tap = 0, out_data = 0. RAM contents are not reset.
- The first edge after release goes to CLEAR if the feature is enabled, otherwise to IDLE with in_ready = 1.
- State IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: write in_data to ram[wr_ptr], latch base = wr_ptr, advance wr_ptr (DEPTH-1 wraps to 0), rd_cnt = 0, go to BURST, in_ready = 0.
- State BURST:
  - A read issues when rd_cnt < DEPTH && (!out_valid || out_ready).
  - Read address = (base - rd_cnt) mod DEPTH, computed without overflow. When base < rd_cnt, the address is base + DEPTH - rd_cnt.
  - Read data is registered: the beat appears on out_* one edge after issue, with out_tap = rd_cnt and out_last = (rd_cnt == DEPTH-1). rd_cnt then increments.
  - No read issues while out_valid && !out_ready. In that case out_data, out_tap and out_last must hold stable.
  - When the last beat is accepted, out_valid drops on the next edge, the FSM goes to IDLE, and in_ready = 1 from that edge.
- Latency and throughput:
  - Sample accepted at edge n; tap 0 is valid from edge n+1.
  - The tap 0 read observes the value written at edge n (read-after-write correct).
  - With out_ready held high: one beat per cycle, last beat at edge n+DEPTH, next sample acceptable at edge n+DEPTH+1.
- in_valid while in_ready = 0 is ignored; the upstream holds the sample.
- Pre-fill taps: without the feature, taps never written return undefined RAM content.
- Reset mid-burst: the burst is abandoned and no further beats appear. wr_ptr returns to 0, so the history is logically discarded.

Optional Feature:
- Macro: EQ_TAP_RING_CLEAR_EN.
- Defined: after reset release the FSM enters CLEAR and writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles). in_ready = 0 and busy = 1 throughout. It then enters IDLE. Pre-fill taps read as 0.
- Undefined: no CLEAR state. IDLE is entered on the first edge after release; pre-fill taps are undefined.

Decomposition:
- Package eq_ram_pkg:
  - DEFAULT_DEPTH = 279, DEFAULT_WIDTH = 16.
  - State enum {IDLE, BURST, CLEAR}.
  - Wrap-subtract function for the modulo address.
- Sub-module eq_sdp_ram: simple dual-port RAM, one write port, one read port with read-enable and a registered output, parametrised DEPTH/WIDTH. The read enable is what gives the hold-on-backpressure behaviour.
- FSM, pointers and handshake logic live in eq_tap_ring_buffer.

Test Plan:
- Basic ordering: DEPTH=4, feature on, out_ready=1; send 1,2,3 -> third burst outputs 3,2,1,0 with taps 0..3 and out_last on tap 3; tap 0 valid one edge after acceptance.
- Wrap-around: DEPTH=5 (non-power-of-2); send 10..17 -> last burst is 17,16,15,14,13; no out-of-range address (assertion addr < DEPTH).
- Backpressure: DEPTH=4; drop out_ready for 3 cycles on tap 1 -> out_data/out_tap stable while stalled, no beat lost or duplicated, in_ready stays 0 until the last beat is accepted.
- Input blocking: hold in_valid=1 with data 0x7FFF then 0x8000 during a burst -> only one sample accepted per burst; the next burst starts at tap 0 = 0x8000.
- Reset mid-burst: assert rst_n=0 at tap 2 -> out_valid=0 immediately (async). After release with the feature on: busy=1 and in_ready=0 for DEPTH cycles, then the first burst returns new sample followed by zeros.
- Feature off: DEPTH=4, no macro -> in_ready=1 on the first edge after release, and there are no CLEAR cycles.
